// File: rtl/mips_multicycle.sv
// Multicycle MIPS core (add/sub/and/or/slt, addi, lw, sw, beq, j) with one shared ALU
// and a req/ready memory port. Defining MIPS_MC_PERF_EN adds cycle_cnt/instr_cnt outputs.
module mips_multicycle #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        ra3,
    output logic [31:0]       rd3,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc_current,
    output logic              instr_done
`ifdef MIPS_MC_PERF_EN
    ,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       instr_cnt
`endif
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC, S_IMMEX, S_MEMADDR, S_MEMRD,
        S_MEMWR, S_WBALU, S_WBMEM, S_BRANCH, S_JUMP
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_SLT   = 6'h2A;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] alu_out_q, alu_out_d;
    logic [31:0] mdr_q, mdr_d;
    logic [31:0] regs_q [32];

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        req_c, we_c, done_c;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm_sext;
    logic        r_ok;

    assign opcode   = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign funct    = ir_q[5:0];
    assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
    assign r_ok     = (funct == F_ADD) || (funct == F_SUB) || (funct == F_AND) ||
                      (funct == F_OR)  || (funct == F_SLT);

    // The single ALU is time-shared: PC+4 in FETCH, branch target in DECODE, data ops later.
    logic [31:0] alu_a, alu_b, alu_y;
    logic [5:0]  alu_fn;

    always_comb begin
        alu_a  = a_q;
        alu_b  = imm_sext;
        alu_fn = F_ADD;
        case (state_q)
            S_FETCH: begin
                alu_a = pc_q;
                alu_b = 32'd4;
            end
            S_DECODE: begin
                alu_a = pc_q;
                alu_b = {imm_sext[29:0], 2'b00};
            end
            S_EXEC: begin
                alu_b  = b_q;
                alu_fn = funct;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (alu_fn)
            F_SUB:   alu_y = alu_a - alu_b;
            F_AND:   alu_y = alu_a & alu_b;
            F_OR:    alu_y = alu_a | alu_b;
            F_SLT:   alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_y = alu_a + alu_b;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_out_d = alu_out_q;
        mdr_d     = mdr_q;
        rf_we     = 1'b0;
        rf_waddr  = 5'd0;
        rf_wdata  = 32'd0;
        req_c     = 1'b0;
        we_c      = 1'b0;
        done_c    = 1'b0;
        case (state_q)
            S_FETCH: begin
                req_c = 1'b1;
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = alu_y;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d       = regs_q[rs];
                b_d       = regs_q[rt];
                alu_out_d = alu_y;
                case (opcode)
                    OP_R: begin
                        state_d = r_ok ? S_EXEC : S_FETCH;
                        done_c  = !r_ok;
                    end
                    OP_ADDI:      state_d = S_IMMEX;
                    OP_LW, OP_SW: state_d = S_MEMADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d = S_FETCH;
                        done_c  = 1'b1;
                    end
                endcase
            end
            S_EXEC, S_IMMEX: begin
                alu_out_d = alu_y;
                state_d   = S_WBALU;
            end
            S_WBALU: begin
                rf_we    = 1'b1;
                rf_waddr = (opcode == OP_R) ? rd : rt;
                rf_wdata = alu_out_q;
                done_c   = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMADDR: begin
                alu_out_d = alu_y;
                state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                req_c = 1'b1;
                if (mem_ready) begin
                    mdr_d   = mem_rdata;
                    state_d = S_WBMEM;
                end
            end
            S_WBMEM: begin
                rf_we    = 1'b1;
                rf_waddr = rt;
                rf_wdata = mdr_q;
                done_c   = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                req_c = 1'b1;
                we_c  = 1'b1;
                if (mem_ready) begin
                    done_c  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_BRANCH: begin
                if (a_q == b_q) pc_d = alu_out_q;
                done_c  = 1'b1;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
                done_c  = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            mdr_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
            mdr_q     <= mdr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (rf_we && rf_waddr != 5'd0) begin
            regs_q[rf_waddr] <= rf_wdata;
        end
    end

    // Reset gates the request combinationally so an in-flight access is aborted at once.
    assign mem_req    = req_c & ~rst;
    assign mem_we     = we_c & ~rst;
    assign instr_done = done_c & ~rst;
    assign mem_addr   = (state_q == S_FETCH) ? pc_q[ADDR_W-1:0] : alu_out_q[ADDR_W-1:0];
    assign mem_wdata  = b_q;
    assign pc_current = pc_q[ADDR_W-1:0];
    assign rd3        = regs_q[ra3];

`ifdef MIPS_MC_PERF_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] instr_cnt_q, instr_cnt_d;

    always_comb begin
        cycle_cnt_d = cycle_cnt_q + 32'd1;
        instr_cnt_d = instr_cnt_q + {31'd0, done_c};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_mips_multicycle.sv
// Bench for mips_multicycle: variable-latency memory model plus an instruction-level
// reference model; directed scenarios followed by a randomized instruction stream.
`timescale 1ns/1ps
module tb_mips_multicycle;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  ra3 = 5'd0;
    logic [31:0] rd3;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ready = 1'b0;
    logic [31:0] pc_current;
    logic        instr_done;
`ifdef MIPS_MC_PERF_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    always #5 clk = ~clk;

    mips_multicycle #(.RESET_PC(RESET_PC), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .ra3(ra3), .rd3(rd3),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc_current(pc_current), .instr_done(instr_done)
`ifdef MIPS_MC_PERF_EN
        , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
    );

    // Memory contents seen by the DUT, and the reference model's architectural state
    logic [31:0] dmem     [256];
    logic [31:0] ref_mem  [256];
    logic [31:0] ref_regs [32];
    logic [31:0] ref_pc;

    int          wait_cycles = 0;
    int          wait_cnt    = 0;
    bit          in_req      = 0;
    logic [31:0] req_addr, req_wdata;
    logic        req_we;
    int          stab_viol   = 0;
    bit          pend_we     = 0;
    logic [31:0] pend_addr, pend_data;
    int          wr_count    = 0;
    logic [31:0] last_wr_addr = 32'd0, last_wr_data = 32'd0;

    int n_checks    = 0;
    int n_fail      = 0;
    int done_pulses = 0;

    // Memory responder: decides ready for the coming edge and watches request stability
    always @(negedge clk) begin
        if (mem_req === 1'b1) begin
            if (!in_req) begin
                in_req    = 1;
                req_addr  = mem_addr;
                req_we    = mem_we;
                req_wdata = mem_wdata;
            end else if (mem_addr !== req_addr || mem_we !== req_we || mem_wdata !== req_wdata) begin
                stab_viol++;
            end
            if (wait_cnt >= wait_cycles) begin
                mem_ready = 1'b1;
                mem_rdata = dmem[mem_addr[9:2]];
                wait_cnt  = 0;
                in_req    = 0;
                if (mem_we === 1'b1) begin
                    pend_we   = 1;
                    pend_addr = mem_addr;
                    pend_data = mem_wdata;
                end
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
                wait_cnt++;
            end
        end else begin
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            wait_cnt  = 0;
            in_req    = 0;
        end
    end

    always @(posedge clk) begin
        if (pend_we) begin
            if (!rst) begin
                dmem[pend_addr[9:2]] = pend_data;
                wr_count++;
                last_wr_addr = pend_addr;
                last_wr_data = pend_data;
            end
            pend_we = 0;
        end
    end

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic put_instr(input logic [31:0] addr, input logic [31:0] word);
        dmem[addr[9:2]]    = word;
        ref_mem[addr[9:2]] = word;
    endtask

    // Executes one instruction architecturally; returns ready=1 latency and memory access count
    task automatic ref_exec(output int base, output int nacc);
        logic [31:0] ins, a, b, simm, ea;
        logic [4:0]  rt, rd;
        ins    = ref_mem[ref_pc[9:2]];
        ref_pc = ref_pc + 32'd4;
        a      = ref_regs[ins[25:21]];
        b      = ref_regs[ins[20:16]];
        rt     = ins[20:16];
        rd     = ins[15:11];
        simm   = {{16{ins[15]}}, ins[15:0]};
        ea     = a + simm;
        base   = 2;
        nacc   = 1;
        case (ins[31:26])
            6'h00: begin
                base = 4;
                case (ins[5:0])
                    6'h20:   ref_regs[rd] = a + b;
                    6'h22:   ref_regs[rd] = a - b;
                    6'h24:   ref_regs[rd] = a & b;
                    6'h25:   ref_regs[rd] = a | b;
                    6'h2A:   ref_regs[rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: base = 2;
                endcase
            end
            6'h08: begin base = 4; ref_regs[rt] = ea; end
            6'h23: begin base = 5; nacc = 2; ref_regs[rt] = ref_mem[ea[9:2]]; end
            6'h2B: begin base = 4; nacc = 2; ref_mem[ea[9:2]] = b; end
            6'h04: begin base = 3; if (a == b) ref_pc = ref_pc + (simm << 2); end
            6'h02: begin base = 3; ref_pc = {ref_pc[31:28], ins[25:0], 2'b00}; end
            default: base = 2;
        endcase
        ref_regs[0] = 32'd0;
    endtask

    // Advances the DUT through one instruction; returns observed and predicted cycle counts
    task automatic do_step(output int got, output int exp);
        int base, nacc;
        bit ok;
        ref_exec(base, nacc);
        exp = base + wait_cycles * nacc;
        got = 0;
        ok  = 0;
        while (!ok && got < exp + 20) begin
            @(negedge clk); #2;
            got++;
            if (instr_done === 1'b1) ok = 1;
        end
        if (ok) begin
            done_pulses++;
            @(posedge clk); #1;
        end
    endtask

    task automatic read_reg(input logic [4:0] r, output logic [31:0] v);
        ra3 = r;
        #0.1;
        v = rd3;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mem_req: got %b expected 0", mem_req); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mem_we: got %b expected 0", mem_we); end
        n_checks++; if (instr_done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_instr_done: got %b expected 0", instr_done); end
        n_checks++; if (pc_current !== RESET_PC) begin n_fail++; $display("[TB] FAIL reset_pc: got %h expected %h", pc_current, RESET_PC); end
        read_reg(5'd7, v);
        n_checks++; if (v !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_reg7: got %h expected 0", v); end
`ifdef MIPS_MC_PERF_EN
        n_checks++; if (cycle_cnt !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_cycle_cnt: got %0d expected 0", cycle_cnt); end
`endif
        ref_pc = RESET_PC;
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic_alu;
        int got, exp, total;
        logic [31:0] v;
        put_instr(32'h0, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
        put_instr(32'h4, enc_i(6'h08, 5'd0, 5'd2, 16'd7));
        put_instr(32'h8, enc_r(5'd1, 5'd2, 5'd3, 6'h20));
        total = 0;
        done_pulses = 0;
        for (int i = 0; i < 3; i++) begin
            do_step(got, exp);
            total += got;
            n_checks++; if (got !== 4) begin n_fail++; $display("[TB] FAIL alu_latency[%0d]: got %0d expected 4", i, got); end
            n_checks++; if (pc_current !== ref_pc) begin n_fail++; $display("[TB] FAIL alu_pc[%0d]: got %h expected %h", i, pc_current, ref_pc); end
        end
        read_reg(5'd3, v);
        n_checks++; if (v !== 32'd12) begin n_fail++; $display("[TB] FAIL alu_rd3_r3: got %0d expected 12", v); end
        n_checks++; if (total !== 12) begin n_fail++; $display("[TB] FAIL alu_total_cycles: got %0d expected 12", total); end
        n_checks++; if (done_pulses !== 3) begin n_fail++; $display("[TB] FAIL alu_done_pulses: got %0d expected 3", done_pulses); end
`ifdef MIPS_MC_PERF_EN
        n_checks++; if (cycle_cnt !== 32'd12) begin n_fail++; $display("[TB] FAIL perf_cycle_cnt: got %0d expected 12", cycle_cnt); end
        n_checks++; if (instr_cnt !== 32'd3) begin n_fail++; $display("[TB] FAIL perf_instr_cnt: got %0d expected 3", instr_cnt); end
`endif
    endtask

    task automatic test_load_store;
        int got, exp, wr_before;
        logic [31:0] v;
        put_instr(ref_pc, enc_i(6'h2B, 5'd0, 5'd3, 16'd4));
        put_instr(ref_pc + 32'd4, enc_i(6'h23, 5'd0, 5'd4, 16'd4));
        wr_before = wr_count;
        do_step(got, exp);
        n_checks++; if (got !== 4) begin n_fail++; $display("[TB] FAIL sw_latency: got %0d expected 4", got); end
        n_checks++; if (wr_count !== wr_before + 1) begin n_fail++; $display("[TB] FAIL sw_write_count: got %0d expected %0d", wr_count, wr_before + 1); end
        n_checks++; if (last_wr_addr !== 32'd4) begin n_fail++; $display("[TB] FAIL sw_addr: got %h expected 4", last_wr_addr); end
        n_checks++; if (last_wr_data !== 32'd12) begin n_fail++; $display("[TB] FAIL sw_data: got %0d expected 12", last_wr_data); end
        do_step(got, exp);
        n_checks++; if (got !== 5) begin n_fail++; $display("[TB] FAIL lw_latency: got %0d expected 5", got); end
        read_reg(5'd4, v);
        n_checks++; if (v !== 32'd12) begin n_fail++; $display("[TB] FAIL lw_rd3_r4: got %0d expected 12", v); end
    endtask

    task automatic test_wait_states;
        int got, exp;
        logic [31:0] v;
        wait_cycles = 3;
        put_instr(ref_pc, enc_r(5'd1, 5'd2, 5'd5, 6'h20));
        do_step(got, exp);
        n_checks++; if (got !== 7) begin n_fail++; $display("[TB] FAIL wait_add_latency: got %0d expected 7", got); end
        read_reg(5'd5, v);
        n_checks++; if (v !== 32'd12) begin n_fail++; $display("[TB] FAIL wait_add_result: got %0d expected 12", v); end
        n_checks++; if (stab_viol !== 0) begin n_fail++; $display("[TB] FAIL wait_stability: got %0d violations expected 0", stab_viol); end
        wait_cycles = 0;
    endtask

    task automatic test_branch_jump;
        int got, exp;
        logic [31:0] beq_addr;
        beq_addr = ref_pc;
        put_instr(beq_addr, enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF));
        do_step(got, exp);
        n_checks++; if (got !== 3) begin n_fail++; $display("[TB] FAIL beq_latency: got %0d expected 3", got); end
        n_checks++; if (pc_current !== beq_addr) begin n_fail++; $display("[TB] FAIL beq_loop_pc: got %h expected %h", pc_current, beq_addr); end
        put_instr(beq_addr, {6'h02, 26'h40});
        do_step(got, exp);
        n_checks++; if (got !== 3) begin n_fail++; $display("[TB] FAIL j_latency: got %0d expected 3", got); end
        n_checks++; if (pc_current !== 32'h100) begin n_fail++; $display("[TB] FAIL j_pc: got %h expected 00000100", pc_current); end
    endtask

    task automatic test_zero_nop;
        int got, exp;
        logic [31:0] v;
        put_instr(ref_pc, enc_i(6'h08, 5'd0, 5'd0, 16'd9));
        put_instr(ref_pc + 32'd4, {6'h3F, 26'h0});
        do_step(got, exp);
        read_reg(5'd0, v);
        n_checks++; if (v !== 32'd0) begin n_fail++; $display("[TB] FAIL r0_write_discard: got %h expected 0", v); end
        do_step(got, exp);
        n_checks++; if (got !== 2) begin n_fail++; $display("[TB] FAIL nop_latency: got %0d expected 2", got); end
        n_checks++; if (pc_current !== 32'h108) begin n_fail++; $display("[TB] FAIL nop_pc: got %h expected 00000108", pc_current); end
    endtask

    task automatic test_random;
        int got, exp, sel;
        logic [31:0] v, ins;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  fn;
        for (int n = 0; n < 30; n++) begin
            wait_cycles = $urandom_range(0, 2);
            sel = $urandom_range(0, 8);
            rs  = 5'($urandom_range(0, 7));
            rt  = 5'($urandom_range(0, 7));
            rd  = 5'($urandom_range(0, 7));
            case (sel)
                0: fn = 6'h20;
                1: fn = 6'h22;
                2: fn = 6'h24;
                3: fn = 6'h25;
                default: fn = 6'h2A;
            endcase
            case (sel)
                5: ins = enc_i(6'h08, rs, rt, 16'($urandom));
                6: ins = enc_i(6'h23, 5'd0, rt, 16'(32'h200 + 4 * $urandom_range(0, 31)));
                7: ins = enc_i(6'h2B, 5'd0, rt, 16'(32'h200 + 4 * $urandom_range(0, 31)));
                8: ins = enc_i(6'h04, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom_range(0, 2)));
                default: ins = enc_r(rs, rt, rd, fn);
            endcase
            put_instr(ref_pc, ins);
            do_step(got, exp);
            n_checks++; if (got !== exp) begin n_fail++; $display("[TB] FAIL rand_latency[%0d] ins=%h: got %0d expected %0d", n, ins, got, exp); end
            n_checks++; if (pc_current !== ref_pc) begin n_fail++; $display("[TB] FAIL rand_pc[%0d]: got %h expected %h", n, pc_current, ref_pc); end
            for (int r = 0; r < 8; r++) begin
                read_reg(5'(r), v);
                n_checks++; if (v !== ref_regs[r]) begin n_fail++; $display("[TB] FAIL rand_reg[%0d] $%0d: got %h expected %h", n, r, v, ref_regs[r]); end
            end
        end
        for (int w = 128; w < 160; w++) begin
            n_checks++; if (dmem[w] !== ref_mem[w]) begin n_fail++; $display("[TB] FAIL rand_mem word %0d: got %h expected %h", w, dmem[w], ref_mem[w]); end
        end
        n_checks++; if (stab_viol !== 0) begin n_fail++; $display("[TB] FAIL rand_stability: got %0d violations expected 0", stab_viol); end
        wait_cycles = 0;
    endtask

    task automatic test_reset_midop;
        int got, exp, wr_before;
        bit seen;
        logic [31:0] saved, v;
        wait_cycles = 6;
        saved = ~ref_regs[1];
        dmem[255]    = saved;
        ref_mem[255] = saved;
        put_instr(ref_pc, enc_i(6'h2B, 5'd0, 5'd1, 16'h03FC));
        seen = 0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clk); #2;
            if (mem_req === 1'b1 && mem_we === 1'b1) seen = 1;
        end
        n_checks++; if (!seen) begin n_fail++; $display("[TB] FAIL midop_reach_write: got no write request expected one within 60 cycles"); end
        wr_before = wr_count;
        rst = 1'b1;
        #1;
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL midop_req_drop: got %b expected 0", mem_req); end
        n_checks++; if (pc_current !== RESET_PC) begin n_fail++; $display("[TB] FAIL midop_pc: got %h expected %h", pc_current, RESET_PC); end
`ifdef MIPS_MC_PERF_EN
        n_checks++; if (cycle_cnt !== 32'd0) begin n_fail++; $display("[TB] FAIL midop_cycle_cnt: got %0d expected 0", cycle_cnt); end
        n_checks++; if (instr_cnt !== 32'd0) begin n_fail++; $display("[TB] FAIL midop_instr_cnt: got %0d expected 0", instr_cnt); end
`endif
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (dmem[255] !== saved) begin n_fail++; $display("[TB] FAIL midop_no_commit: got %h expected %h", dmem[255], saved); end
        n_checks++; if (wr_count !== wr_before) begin n_fail++; $display("[TB] FAIL midop_write_count: got %0d expected %0d", wr_count, wr_before); end
        rst = 1'b0;
        wait_cycles = 0;
        ref_pc = RESET_PC;
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
        read_reg(5'd3, v);
        n_checks++; if (v !== 32'd0) begin n_fail++; $display("[TB] FAIL midop_reg_clear: got %h expected 0", v); end
        do_step(got, exp);
        n_checks++; if (got !== 4) begin n_fail++; $display("[TB] FAIL post_reset_latency: got %0d expected 4", got); end
        read_reg(5'd1, v);
        n_checks++; if (v !== 32'd5) begin n_fail++; $display("[TB] FAIL post_reset_r1: got %0d expected 5", v); end
        n_checks++; if (pc_current !== 32'd4) begin n_fail++; $display("[TB] FAIL post_reset_pc: got %h expected 4", pc_current); end
`ifdef MIPS_MC_PERF_EN
        n_checks++; if (cycle_cnt !== 32'd4) begin n_fail++; $display("[TB] FAIL post_reset_cycle_cnt: got %0d expected 4", cycle_cnt); end
        n_checks++; if (instr_cnt !== 32'd1) begin n_fail++; $display("[TB] FAIL post_reset_instr_cnt: got %0d expected 1", instr_cnt); end
`endif
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            dmem[i]    = (i >= 128) ? $urandom : 32'd0;
            ref_mem[i] = dmem[i];
        end
        test_reset;
        test_basic_alu;
        test_load_store;
        test_wait_states;
        test_branch_jump;
        test_zero_nop;
        test_random;
        test_reset_midop;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
